// File: rtl/count_sequencer.sv
// Three-state up/down count sequencer: steps a 3-bit count every DIV cycles toward a
// latched target, presenting binary, Gray and one-hot views plus busy/done/wrap flags.
module count_sequencer #(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic [2:0] target,
    input  logic       pause,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       wrap,
    output logic [2:0] bin,
    output logic [2:0] gray,
    output logic [7:0] onehot
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] PRESC_LAST = 4'(DIV - 1);

    function automatic logic [2:0] to_gray(input logic [2:0] b);
        return b ^ {1'b0, b[2:1]};
    endfunction

    function automatic logic [7:0] to_onehot(input logic [2:0] b);
        return 8'h01 << b;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] presc_q, presc_d;
    logic [2:0] bin_q, bin_d;
    logic [2:0] gray_q;
    logic [7:0] onehot_q;
    logic       busy_q, done_q;
    logic       wrap_q, wrap_d;
    logic       dir_q, dir_d;
    logic [2:0] target_q, target_d;
    logic [2:0] step_val_s;
    logic       step_wrap_s;

    assign step_val_s  = dir_q ? (bin_q + 3'd1) : (bin_q - 3'd1);
    assign step_wrap_s = dir_q ? (bin_q == 3'd7) : (bin_q == 3'd0);

    // Next-state logic; abort outranks pause, which outranks a prescaler step.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        bin_d    = bin_q;
        dir_d    = dir_q;
        target_d = target_q;
        wrap_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d    = dir;
                    target_d = target;
                    presc_d  = 4'd0;
                    if (target != bin_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    presc_d = 4'd0;
                end else if (pause) begin
                    state_d = ST_RUN;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = 4'd0;
                    bin_d   = step_val_s;
                    wrap_d  = step_wrap_s;
                    if (step_val_s == target_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    presc_d = presc_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = 4'd0;
            end
        endcase
    end

    // State and output registers; outputs are derived from next-state values so they
    // change in the same cycle as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= 4'd0;
            bin_q    <= 3'd0;
            gray_q   <= 3'd0;
            onehot_q <= 8'h01;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            dir_q    <= 1'b1;
            target_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            bin_q    <= bin_d;
            gray_q   <= to_gray(bin_d);
            onehot_q <= to_onehot(bin_d);
            busy_q   <= (state_d == ST_RUN);
            done_q   <= (state_d == ST_DONE);
            wrap_q   <= wrap_d;
            dir_q    <= dir_d;
            target_q <= target_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign wrap   = wrap_q;
    assign bin    = bin_q;
    assign gray   = gray_q;
    assign onehot = onehot_q;

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have parameter DIV, default 1, meaning the number of clk cycles per count step (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, the run request, sampled only in IDLE.
REQ-005 The block SHALL have port dir, input, 1, the direction: 1 = up, 0 = down; latched on an accepted start.
REQ-006 The block SHALL have port target, input, 3, the stop value; latched on an accepted start.
REQ-007 The block SHALL have port pause, input, 1, which freezes stepping while high in RUN.
REQ-008 The block SHALL have port abort, input, 1, which terminates a run without done.
REQ-009 The block SHALL have port busy, output, 1, high exactly while in RUN.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse when the run reaches target.
REQ-011 The block SHALL have port wrap, output, 1, a one-cycle pulse on a 7->0 (up) or 0->7 (down) step.
REQ-012 The block SHALL have port bin, output, 3, the current count in binary.
REQ-013 The block SHALL have port gray, output, 3, the current count in Gray code: bin ^ (bin >> 1).
REQ-014 The block SHALL have port onehot, output, 8, the current count in one-hot form: 1 << bin.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 SHALL latch dir and target; the FSM SHALL go to RUN next cycle if target != bin, else to DONE (zero-step run).
REQ-017 start SHALL be ignored in RUN and DONE; dir and target changes after acceptance SHALL have no effect on the current run.
REQ-018 On entry to RUN, the prescaler SHALL clear to 0; in RUN with pause=0, it SHALL increment each cycle, and a step SHALL occur on the cycle the prescaler equals DIV-1, after which it returns to 0.
REQ-019 A step SHALL change bin by +1 (up) or -1 (down) modulo 8; gray and onehot SHALL update in the same cycle as bin.
REQ-020 wrap SHALL pulse in the cycle the stepped value is visible, only on 7->0 (up) or 0->7 (down).
REQ-021 When a step produces bin == latched target, the FSM SHALL enter DONE in the same cycle the new value is visible.
REQ-022 In DONE, done=1 and busy=0 SHALL hold for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 Latency: done SHALL assert 1 + N*DIV cycles after the start cycle, where N = modulo-8 step distance in the latched direction (N=0 gives done at start+1), with no pause applied.
REQ-024 pause=1 in RUN SHALL hold the prescaler and count; each paused cycle SHALL extend latency by one.
REQ-025 abort=1 in RUN SHALL force IDLE next cycle with no step, no done and bin retained; abort SHALL take priority over pause and over a coincident step.
REQ-026 abort in IDLE or DONE SHALL be ignored.
REQ-027 Count value SHALL persist across runs; a new run SHALL start from the current bin.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, prescaler 0, bin=0, gray=0, onehot=8'h01, busy=0, done=0, wrap=0, latched dir=1, latched target=0.
REQ-029 Reset asserted mid-run SHALL discard the run with no done pulse; operation SHALL resume on the first clk edge after rst deasserts.

Verification
REQ-030 The bench SHALL cover: DIV=1, bin=0, start with dir=1, target=3 -> bin 1,2,3 on start+2..+4, gray 001,011,010, done and busy=0 at start+4, no wrap.
REQ-031 The bench SHALL cover: DIV=1, bin=0, start with dir=0, target=6 -> bin 7 at start+2 with wrap=1, bin 6 at start+3 with done=1, onehot=8'h40.
REQ-032 The bench SHALL cover: DIV=3, bin=5, start with dir=1, target=5 -> done at start+1, no step, busy never high.
REQ-033 The bench SHALL cover: DIV=2, up run to target=4 from 0, pause high 3 cycles mid-run -> done at start+12 (1+8+3), bin monotonic.
REQ-034 The bench SHALL cover: abort and pause asserted on a step cycle -> IDLE next cycle, bin unchanged, done never pulses; a following start with target=bin -> immediate done.
REQ-035 The bench SHALL cover: rst asserted asynchronously mid-run between clk edges -> outputs reach reset values before the next edge; onehot=8'h01.
